// File: rtl/req_gnt_pkg.sv
// Shared types for the multi-channel request/grant handshake monitor.
package req_gnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_e;

    typedef struct packed {
        logic early;
        logic timeout;
        logic spurious;
        logic drop;
    } err_flags_t;

    function automatic int lat_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/req_gnt_ch_fsm.sv
// One channel of the req/gnt monitor: handshake FSM, latency counter,
// registered error pulses and saturating pass counter.
module req_gnt_ch_fsm
    import req_gnt_pkg::*;
#(
    parameter int MIN_LAT  = 1,
    parameter int MAX_LAT  = 8,
    parameter int HOLD_REQ = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             gnt,
    input  logic             clr,
    output logic             busy,
    output err_flags_t       err,
    output err_flags_t       err_evt,
    output logic [CNT_W-1:0] pass_cnt
);

    localparam int LW = lat_w(MAX_LAT);

    ch_state_e     state, state_nx;
    logic [LW-1:0] lat, lat_nx;
    err_flags_t    err_nx;
    logic          pass;

    always_comb begin
        state_nx = state;
        lat_nx   = lat;
        err_nx   = '0;
        pass     = 1'b0;
        unique case (state)
            IDLE: begin
                // A grant in the request cycle is never legal (|=> semantics).
                if (gnt) err_nx.spurious = 1'b1;
                if (req) begin
                    state_nx = WAIT;
                    lat_nx   = LW'(1);
                end
            end
            WAIT: begin
                if (gnt) begin
                    if (lat < LW'(MIN_LAT)) err_nx.early = 1'b1;
                    else                    pass = 1'b1;
                    // req alongside the grant opens the next transaction at once
                    if (req) begin
                        lat_nx = LW'(1);
                    end else begin
                        state_nx = IDLE;
                        lat_nx   = '0;
                    end
                end else if (HOLD_REQ != 0 && !req) begin
                    err_nx.drop = 1'b1;
                    state_nx    = IDLE;
                    lat_nx      = '0;
                end else if (lat == LW'(MAX_LAT)) begin
                    err_nx.timeout = 1'b1;
                    state_nx       = IDLE;
                    lat_nx         = '0;
                end else begin
                    lat_nx = lat + LW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                lat_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat      <= '0;
            err      <= '0;
            pass_cnt <= '0;
        end else begin
            state <= state_nx;
            lat   <= lat_nx;
            err   <= err_nx;
            if (clr)
                pass_cnt <= pass ? CNT_W'(1) : '0;
            else if (pass && pass_cnt != '1)
                pass_cnt <= pass_cnt + CNT_W'(1);
        end
    end

    assign busy    = (state == WAIT);
    assign err_evt = err_nx;

`ifndef SYNTHESIS
    a_err_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(err));
    a_err_needs_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (err.early || err.timeout || err.drop) |-> $past(busy));
`endif

endmodule

// File: rtl/req_gnt_monitor.sv
// Multi-channel req/gnt latency checker: per-channel FSMs plus a sticky
// error summary and packed pass counters.
module req_gnt_monitor
    import req_gnt_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int MIN_LAT  = 1,
    parameter int MAX_LAT  = 8,
    parameter int HOLD_REQ = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       gnt,
    input  logic                    clr,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       err_early,
    output logic [NUM_CH-1:0]       err_timeout,
    output logic [NUM_CH-1:0]       err_spurious,
    output logic [NUM_CH-1:0]       err_drop,
    output logic                    err_sticky,
    output logic [NUM_CH*CNT_W-1:0] pass_cnt
);

    logic [NUM_CH-1:0] evt_any;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        err_flags_t flg, evt;

        req_gnt_ch_fsm #(
            .MIN_LAT  (MIN_LAT),
            .MAX_LAT  (MAX_LAT),
            .HOLD_REQ (HOLD_REQ),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (req[i]),
            .gnt      (gnt[i]),
            .clr      (clr),
            .busy     (busy[i]),
            .err      (flg),
            .err_evt  (evt),
            .pass_cnt (pass_cnt[i*CNT_W +: CNT_W])
        );

        assign err_early[i]    = flg.early;
        assign err_timeout[i]  = flg.timeout;
        assign err_spurious[i] = flg.spurious;
        assign err_drop[i]     = flg.drop;
        assign evt_any[i]      = |evt;
    end

    // Built from the pre-register events so it rises with the first pulse,
    // and a clr in the same cycle as a new error still leaves it set.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (clr)
            err_sticky <= |evt_any;
        else if (|evt_any)
            err_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_req_gnt_monitor.sv
// Directed scoreboard bench for req_gnt_monitor (2 channels, window [2,4]).
module tb_req_gnt_monitor;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       req, gnt;
    logic                    clr;
    logic [NUM_CH-1:0]       busy, err_early, err_timeout, err_spurious, err_drop;
    logic                    err_sticky;
    logic [NUM_CH*CNT_W-1:0] pass_cnt;

    req_gnt_monitor #(
        .NUM_CH(NUM_CH), .MIN_LAT(2), .MAX_LAT(4), .HOLD_REQ(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .clr(clr),
        .busy(busy), .err_early(err_early), .err_timeout(err_timeout),
        .err_spurious(err_spurious), .err_drop(err_drop),
        .err_sticky(err_sticky), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] busy;
        logic [1:0] early;
        logic [1:0] tmo;
        logic [1:0] spur;
        logic [1:0] drop;
        logic       sticky;
        logic [7:0] pc;
    } obs_t;

    obs_t  sb[$];
    string tq[$];
    string tname = "init";
    int    vectors = 0;
    int    fails   = 0;

    // Inputs are applied, then the expectation for the state after the next
    // edge is queued right at that edge.
    task automatic step(input logic rn, input logic [1:0] rq, input logic [1:0] gn,
                        input logic cl, input logic [1:0] eb, input logic [1:0] ee,
                        input logic [1:0] et, input logic [1:0] es, input logic [1:0] ed,
                        input logic est, input logic [3:0] ep1, input logic [3:0] ep0);
        obs_t e;
        rst_n = rn; req = rq; gnt = gn; clr = cl;
        e = '{busy: eb, early: ee, tmo: et, spur: es, drop: ed, sticky: est, pc: {ep1, ep0}};
        @(posedge clk);
        sb.push_back(e);
        tq.push_back(tname);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            obs_t  e, a;
            string n;
            e = sb.pop_front();
            n = tq.pop_front();
            a = '{busy: busy, early: err_early, tmo: err_timeout, spur: err_spurious,
                  drop: err_drop, sticky: err_sticky, pc: pass_cnt};
            vectors++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s vec%0d: got busy=%b early=%b tmo=%b spur=%b drop=%b sticky=%b pc=%h, expected busy=%b early=%b tmo=%b spur=%b drop=%b sticky=%b pc=%h",
                         n, vectors, a.busy, a.early, a.tmo, a.spur, a.drop, a.sticky, a.pc,
                         e.busy, e.early, e.tmo, e.spur, e.drop, e.sticky, e.pc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; gnt = '0; clr = 1'b0;

        tname = "reset";
        step(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(0, 2'b11, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);

        tname = "legal_ch0";
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd1);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd1);

        tname = "early_ch1";
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd1);
        step(1, 2'b00, 2'b10, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);

        tname = "timeout_ch0";
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);

        tname = "spurious_ch1";
        step(1, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);

        tname = "spurious_req_drop_ch0";
        step(1, 2'b01, 2'b01, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1, 4'd0, 4'd1);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 4'd0, 4'd1);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd1);

        tname = "clr_idle";
        step(1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);

        tname = "b2b_saturate_ch0";
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0,
                 4'((k - 1) > 15 ? 15 : (k - 1)));
            step(1, (k < 20) ? 2'b01 : 2'b00, 2'b01, 0, (k < 20) ? 2'b01 : 2'b00,
                 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'(k > 15 ? 15 : k));
        end
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd15);

        tname = "reset_mid_wait";
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd15);
        step(0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);

        tname = "pass_ch1";
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd0, 4'd0);
        step(1, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);

        tname = "clr_with_timeout";
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);
        step(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);
        step(1, 2'b01, 2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 4'd0, 4'd0);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd0);

        tname = "clr_with_pass";
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd0);
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd0, 4'd0);
        step(1, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd1, 4'd0);
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd1, 4'd0);
        step(1, 2'b10, 2'b00, 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4'd1, 4'd0);
        step(1, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);
        step(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4'd1, 4'd0);

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
